// File: rtl/myproject_mul_share_arb.sv
// Round-robin arbiter sharing one unsigned multiplier among NUM_REQ requesters.
// Products travel down a MUL_STAGES-deep pipeline tagged with the issuing requester.
module myproject_mul_share_arb #(
  parameter int NUM_REQ    = 4,
  parameter int DIN0_WIDTH = 31,
  parameter int DIN1_WIDTH = 10,
  parameter int DOUT_WIDTH = 40,
  parameter int MUL_STAGES = 2,
  parameter int ID_WIDTH   = 2
) (
  input  logic                             ap_clk,
  input  logic                             ap_rst,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_REQ*DIN0_WIDTH-1:0]    req_din0,
  input  logic [NUM_REQ*DIN1_WIDTH-1:0]    req_din1,
  output logic                             rsp_valid,
  input  logic                             rsp_ready,
  output logic [DOUT_WIDTH-1:0]            rsp_dout,
  output logic [ID_WIDTH-1:0]              rsp_id,
  output logic                             busy
);

  // Handshakes: a transfer happens on a rising edge where valid & ready are both
  // high. req_ready may look at req_valid; requesters hold valid and operands
  // until accepted. rsp_* hold steady while rsp_valid & ~rsp_ready.

  localparam int PROD_WIDTH = (DIN0_WIDTH + DIN1_WIDTH > DOUT_WIDTH) ?
                              (DIN0_WIDTH + DIN1_WIDTH) : DOUT_WIDTH;
  localparam int IW1 = ID_WIDTH + 1;

  logic [ID_WIDTH-1:0]   ptr;
  logic [ID_WIDTH-1:0]   ptr_next;
  logic [MUL_STAGES-1:0] stg_valid;
  logic [DOUT_WIDTH-1:0] stg_prod [MUL_STAGES];
  logic [ID_WIDTH-1:0]   stg_id   [MUL_STAGES];

  logic                  stall;
  logic                  grant_found;
  logic [ID_WIDTH-1:0]   grant_idx;
  logic [IW1-1:0]        idx;
  logic                  accept;
  logic [DIN0_WIDTH-1:0] a_sel;
  logic [DIN1_WIDTH-1:0] b_sel;
  logic [PROD_WIDTH-1:0] a_ext;
  logic [PROD_WIDTH-1:0] b_ext;
  logic [DOUT_WIDTH-1:0] new_prod;

  assign stall = stg_valid[MUL_STAGES-1] & ~rsp_ready;

  // Search from the pointer upwards, wrapping, for the first valid requester.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    idx         = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = {1'b0, ptr} + IW1'(k);
      if (idx >= IW1'(NUM_REQ)) idx = idx - IW1'(NUM_REQ);
      if (!grant_found && req_valid[idx[ID_WIDTH-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = idx[ID_WIDTH-1:0];
      end
    end
  end

  assign accept = grant_found & ~stall & ~ap_rst;

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[grant_idx] = 1'b1;
  end

  always_comb begin
    if (grant_idx == ID_WIDTH'(NUM_REQ - 1)) ptr_next = '0;
    else                                     ptr_next = grant_idx + 1'b1;
  end

  assign a_sel    = req_din0[grant_idx*DIN0_WIDTH +: DIN0_WIDTH];
  assign b_sel    = req_din1[grant_idx*DIN1_WIDTH +: DIN1_WIDTH];
  assign a_ext    = PROD_WIDTH'(a_sel);
  assign b_ext    = PROD_WIDTH'(b_sel);
  assign new_prod = DOUT_WIDTH'(a_ext * b_ext);

  // Data registers only load behind a valid entry, so the last stage keeps
  // showing the previous result while a bubble sits there.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      ptr       <= '0;
      stg_valid <= '0;
      for (int k = 0; k < MUL_STAGES; k++) begin
        stg_prod[k] <= '0;
        stg_id[k]   <= '0;
      end
    end else begin
      if (accept) ptr <= ptr_next;
      if (!stall) begin
        stg_valid[0] <= accept;
        if (accept) begin
          stg_prod[0] <= new_prod;
          stg_id[0]   <= grant_idx;
        end
        for (int k = 1; k < MUL_STAGES; k++) begin
          stg_valid[k] <= stg_valid[k-1];
          if (stg_valid[k-1]) begin
            stg_prod[k] <= stg_prod[k-1];
            stg_id[k]   <= stg_id[k-1];
          end
        end
      end
    end
  end

  assign rsp_valid = stg_valid[MUL_STAGES-1];
  assign rsp_dout  = stg_prod[MUL_STAGES-1];
  assign rsp_id    = stg_id[MUL_STAGES-1];
  assign busy      = |stg_valid;

endmodule

// File: tb/tb_myproject_mul_share_arb.sv
// Bench for myproject_mul_share_arb: queue-based behavioural model checked at every
// negative edge, plus directed scenarios with hand-computed expectations.
module tb_myproject_mul_share_arb;

  localparam int N   = 4;
  localparam int AW  = 31;
  localparam int BW  = 10;
  localparam int DW  = 40;
  localparam int STG = 2;
  localparam int IW  = 2;
  localparam logic [63:0] MASK = (64'd1 << DW) - 64'd1;

  logic            ap_clk = 1'b0;
  logic            ap_rst = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N*AW-1:0] req_din0 = '0;
  logic [N*BW-1:0] req_din1 = '0;
  logic            rsp_valid;
  logic            rsp_ready = 1'b1;
  logic [DW-1:0]   rsp_dout;
  logic [IW-1:0]   rsp_id;
  logic            busy;

  myproject_mul_share_arb #(
    .NUM_REQ(N), .DIN0_WIDTH(AW), .DIN1_WIDTH(BW), .DOUT_WIDTH(DW),
    .MUL_STAGES(STG), .ID_WIDTH(IW)
  ) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_din0(req_din0), .req_din1(req_din1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_dout(rsp_dout), .rsp_id(rsp_id), .busy(busy)
  );

  // clock / reset
  always #5 ap_clk = ~ap_clk;

  typedef struct { int req; logic [63:0] a; logic [63:0] b; } op_t;
  typedef struct { int id; logic [63:0] prod; int pos; } ent_t;

  op_t  pq[$];         // pending stimulus per requester
  ent_t exp_q[$];      // in-flight products, oldest first
  ent_t deliv[$];      // results handed off downstream
  int   grant_log[$];

  int          errors = 0;
  int          checks = 0;
  int          ptr = 0;
  int          n_acc = 0;
  logic [63:0] last_dout = '0;
  int          last_id = 0;
  bit          chk_en = 1'b0;
  logic [N-1:0] acc_seen = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard / model: outputs derive from the queue of in-flight entries
  logic         m_valid, m_stall, m_found;
  int           m_g, m_idx;
  logic [N-1:0] m_ready;
  logic [63:0]  m_dout;
  int           m_id;
  logic [AW-1:0] m_a;
  logic [BW-1:0] m_b;
  ent_t          m_ent;

  always @(negedge ap_clk) begin
    if (chk_en) begin
      m_valid = (exp_q.size() > 0) && (exp_q[0].pos == STG - 1);
      m_dout  = m_valid ? exp_q[0].prod : last_dout;
      m_id    = m_valid ? exp_q[0].id : last_id;
      m_stall = m_valid && !rsp_ready;
      m_found = 1'b0;
      m_g = 0;
      for (int k = 0; k < N; k++) begin
        m_idx = (ptr + k) % N;
        if (!m_found && req_valid[m_idx]) begin
          m_found = 1'b1;
          m_g = m_idx;
        end
      end
      m_ready = '0;
      if (m_found && !m_stall && !ap_rst) m_ready[m_g] = 1'b1;

      chk("req_ready", 64'(req_ready), 64'(m_ready));
      chk("rsp_valid", 64'(rsp_valid), 64'(m_valid));
      chk("rsp_dout", 64'(rsp_dout), m_dout);
      chk("rsp_id", 64'(rsp_id), 64'(m_id));
      chk("busy", 64'(busy), 64'(exp_q.size() > 0));

      acc_seen = req_valid & req_ready & {N{~ap_rst}};

      if (ap_rst) begin
        exp_q.delete();
        ptr = 0;
        last_dout = '0;
        last_id = 0;
      end else begin
        if (m_valid) begin
          last_dout = m_dout;
          last_id = m_id;
        end
        if (!m_stall) begin
          if (m_valid) begin
            deliv.push_back(exp_q[0]);
            void'(exp_q.pop_front());
          end
          foreach (exp_q[j]) exp_q[j].pos = exp_q[j].pos + 1;
          if (m_found) begin
            m_a = req_din0[m_g*AW +: AW];
            m_b = req_din1[m_g*BW +: BW];
            m_ent.id = m_g;
            m_ent.prod = (64'(m_a) * 64'(m_b)) & MASK;
            m_ent.pos = 0;
            exp_q.push_back(m_ent);
            grant_log.push_back(m_g);
            ptr = (m_g + 1) % N;
            n_acc++;
          end
        end
      end
    end
  end

  // driver: each requester holds its request until it has been accepted
  logic [63:0] d_a, d_b;
  bit          d_done;
  initial begin
    forever begin
      @(posedge ap_clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (acc_seen[i]) req_valid[i] = 1'b0;
        if (!req_valid[i]) begin
          d_done = 1'b0;
          for (int j = 0; j < pq.size(); j++) begin
            if (!d_done && pq[j].req == i) begin
              d_a = pq[j].a;
              d_b = pq[j].b;
              req_din0[i*AW +: AW] = d_a[AW-1:0];
              req_din1[i*BW +: BW] = d_b[BW-1:0];
              req_valid[i] = 1'b1;
              pq.delete(j);
              d_done = 1'b1;
            end
          end
        end
      end
      acc_seen = '0;
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge ap_clk);
      #2;
    end
  endtask

  task automatic push(input int r, input logic [63:0] a, input logic [63:0] b);
    op_t o;
    o.req = r;
    o.a = a;
    o.b = b;
    pq.push_back(o);
  endtask

  task automatic wait_idle();
    int t = 0;
    while (!(pq.size() == 0 && req_valid == '0 && exp_q.size() == 0) && t < 300) begin
      cyc(1);
      t++;
    end
    chk("idle_reached", 64'(t < 300), 64'd1);
    cyc(2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  int          bg, bd, na0, tw;
  logic [63:0] d0;

  initial begin
    ap_rst = 1'b1;
    rsp_ready = 1'b1;
    @(posedge ap_clk);
    #1;
    chk_en = 1'b1;
    cyc(2);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_rsp_dout", 64'(rsp_dout), 64'd0);
    chk("rst_rsp_id", 64'(rsp_id), 64'd0);
    ap_rst = 1'b0;
    cyc(2);

    // fairness: all four requesters hold two requests each, pointer starts at 0
    bg = grant_log.size();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < N; i++)
        push(i, 64'(100 * (i + 1) + k + 1), 64'(3 * i + k + 2));
    wait_idle();
    chk("fair_count", 64'(grant_log.size() - bg), 64'd8);
    for (int i = 0; i < 8; i++) chk("fair_order", 64'(grant_log[bg+i]), 64'(i % 4));

    // single request from requester 2
    bd = deliv.size();
    push(2, 64'd1000, 64'd3);
    wait_idle();
    chk("single_count", 64'(deliv.size() - bd), 64'd1);
    chk("single_id", 64'(deliv[bd].id), 64'd2);
    chk("single_dout", deliv[bd].prod, 64'd3000);
    chk("single_busy", 64'(busy), 64'd0);

    // overflow truncation to the low 40 bits
    bd = deliv.size();
    push(0, 64'd2147483647, 64'd1023);
    wait_idle();
    chk("ovf_dout", deliv[bd].prod, 64'd1097364143105);
    chk("ovf_id", 64'(deliv[bd].id), 64'd0);

    // sparse valid with wrap: move pointer to 3, then requesters 1 and 3
    push(2, 64'd5, 64'd6);
    wait_idle();
    bg = grant_log.size();
    push(1, 64'd7, 64'd8);
    push(3, 64'd9, 64'd10);
    wait_idle();
    chk("wrap_first", 64'(grant_log[bg]), 64'd3);
    chk("wrap_second", 64'(grant_log[bg+1]), 64'd1);
    cyc(5);
    bg = grant_log.size();
    push(0, 64'd11, 64'd12);
    push(2, 64'd13, 64'd14);
    wait_idle();
    chk("idle_ptr_first", 64'(grant_log[bg]), 64'd2);
    chk("idle_ptr_second", 64'(grant_log[bg+1]), 64'd0);

    // backpressure mid-stream
    bd = deliv.size();
    for (int k = 0; k < 6; k++) push(1, 64'(10 * k + 1), 64'(k + 2));
    cyc(3);
    rsp_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      #1;
      if (s == 0) d0 = 64'(rsp_dout);
      chk("stall_ready", 64'(req_ready), 64'd0);
      chk("stall_valid", 64'(rsp_valid), 64'd1);
      chk("stall_dout", 64'(rsp_dout), 64'd2);
      chk("stall_frozen", 64'(rsp_dout), d0);
      @(posedge ap_clk);
      #2;
    end
    rsp_ready = 1'b1;
    wait_idle();
    chk("bp_count", 64'(deliv.size() - bd), 64'd6);
    for (int k = 0; k < 6; k++) begin
      chk("bp_order", deliv[bd+k].prod, 64'((10 * k + 1) * (k + 2)));
      chk("bp_id", 64'(deliv[bd+k].id), 64'd1);
    end

    // reset with two products in flight
    rsp_ready = 1'b0;
    bd = deliv.size();
    na0 = n_acc;
    push(3, 64'd21, 64'd22);
    push(0, 64'd23, 64'd24);
    tw = 0;
    while (n_acc < na0 + 2 && tw < 50) begin
      cyc(1);
      tw++;
    end
    chk("mid_accepts", 64'(n_acc - na0), 64'd2);
    ap_rst = 1'b1;
    cyc(1);
    ap_rst = 1'b0;
    rsp_ready = 1'b1;
    #1;
    chk("post_rst_valid", 64'(rsp_valid), 64'd0);
    chk("post_rst_busy", 64'(busy), 64'd0);
    chk("post_rst_dout", 64'(rsp_dout), 64'd0);
    cyc(4);
    chk("post_rst_no_result", 64'(deliv.size() - bd), 64'd0);
    bg = grant_log.size();
    push(3, 64'd25, 64'd26);
    push(0, 64'd27, 64'd28);
    wait_idle();
    chk("post_rst_ptr_first", 64'(grant_log[bg]), 64'd0);
    chk("post_rst_ptr_second", 64'(grant_log[bg+1]), 64'd3);
    chk("post_rst_count", 64'(deliv.size() - bd), 64'd2);
    chk("post_rst_dout0", deliv[bd].prod, 64'd756);
    chk("post_rst_dout1", deliv[bd+1].prod, 64'd650);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
